// File: rtl/clahe_pkg.sv
// ---------------------------------------------------------------------------
// clahe_pkg
// Shared definitions for the CLAHE histogram path. The bin/count widths here
// are the defaults used by the run decoder and by the per-tile histogram
// accumulator. run_rec_t is the (bin, count, last) record passed between
// them.
// ---------------------------------------------------------------------------
package clahe_pkg;

  localparam int BIN_W     = 5;
  localparam int RUN_CNT_W = 8;

  typedef struct packed {
    logic [BIN_W-1:0]     bin;
    logic [RUN_CNT_W-1:0] cnt;
    logic                 last;
  } run_rec_t;

endpackage

// File: rtl/onehot_decoder.sv
// ---------------------------------------------------------------------------
// onehot_decoder
// Purely combinational decoder. It turns a binary index into a one-hot
// vector that is 2**IN_W bits wide.
// Ports:
//   idx_i     in   IN_W       binary index
//   onehot_o  out  2**IN_W    one-hot result, bit idx_i set
// ---------------------------------------------------------------------------
module onehot_decoder #(
  parameter int IN_W = 5
) (
  input  logic [IN_W-1:0]      idx_i,
  output logic [2**IN_W-1:0]   onehot_o
);

  // Set only the bit selected by the index.
  always_comb begin
    onehot_o        = '0;
    onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/hist_bin_run_decoder.sv
// ---------------------------------------------------------------------------
// hist_bin_run_decoder
// Takes a stream of pixel bin indices. Consecutive equal bins are merged into
// (bin, count) runs. Each run is presented as a registered one-hot bin select
// together with its run length. Merging repeated bins here keeps the
// histogram RAM from seeing back-to-back read-modify-writes to one address.
//
// The datapath has two register stages:
//   hold (H)   - the run that is currently growing
//   output (O) - the finished run offered downstream
//
// Ports:
//   clk         in   1        clock, rising edge
//   rst         in   1        asynchronous active-high reset
//   clr         in   1        synchronous flush of H and O
//   in_valid    in   1        input bin valid
//   in_ready    out  1        input accepted when in_valid & in_ready
//   in_bin      in   IN_W     pixel bin index
//   in_last     in   1        last pixel of tile, closes the run
//   out_valid   out  1        output entry valid
//   out_ready   in   1        downstream accepts when out_valid & out_ready
//   out_onehot  out  2**IN_W  one-hot of out_bin, zero while out_valid=0
//   out_bin     out  IN_W     bin index of run
//   out_cnt     out  CNT_W    run length, 1..MAX_RUN
//   out_last    out  1        run ends the tile
//
// in_ready depends combinationally on in_bin through the merge check. The
// upstream stage must therefore not derive in_valid or in_bin from in_ready.
// ---------------------------------------------------------------------------
module hist_bin_run_decoder
  import clahe_pkg::*;
#(
  parameter int IN_W     = BIN_W,
  parameter int CNT_W    = RUN_CNT_W,
  parameter int MAX_RUN  = 255,
  parameter int IDLE_CYC = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_W-1:0]     in_bin,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2**IN_W-1:0]  out_onehot,
  output logic [IN_W-1:0]     out_bin,
  output logic [CNT_W-1:0]    out_cnt,
  output logic                out_last
);

  localparam int OUT_W  = 2**IN_W;
  localparam int IDLE_W = (IDLE_CYC > 0) ? $clog2(IDLE_CYC + 1) : 1;
  localparam logic [CNT_W-1:0]  MAX_RUN_C = CNT_W'(MAX_RUN);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_CYC);
  localparam bit                IDLE_EN   = (IDLE_CYC != 0);

  // Hold register: the run that is still being built.
  logic              holdValid_q, holdValid_d;
  logic [IN_W-1:0]   holdBin_q,   holdBin_d;
  logic [CNT_W-1:0]  holdCnt_q,   holdCnt_d;
  logic              holdLast_q,  holdLast_d;

  // Output register: the run offered downstream.
  logic              outValid_q,  outValid_d;
  logic [IN_W-1:0]   outBin_q,    outBin_d;
  logic [CNT_W-1:0]  outCnt_q,    outCnt_d;
  logic              outLast_q,   outLast_d;
  logic [OUT_W-1:0]  outOnehot_q, outOnehot_d;

  logic [IDLE_W-1:0] idleCnt_q,   idleCnt_d;

  logic              oFree;
  logic              merge;
  logic              accept;
  logic              idleExpired;
  logic              pushIdle;
  logic              loadO;
  logic [OUT_W-1:0]  holdOnehot;

  onehot_decoder #(.IN_W(IN_W)) u_decode (
    .idx_i    (holdBin_q),
    .onehot_o (holdOnehot)
  );

  // Handshake and transfer decisions.
  // A pixel that cannot merge moves H into O, so that pixel is only taken
  // when O is free or already draining this cycle. clr overrides an accept:
  // the pixel is consumed on the bus but it is discarded.
  always_comb begin
    oFree       = !outValid_q || out_ready;
    merge       = holdValid_q && !holdLast_q && (in_bin == holdBin_q)
                  && (holdCnt_q < MAX_RUN_C);
    in_ready    = !rst && (!holdValid_q || oFree || merge);
    accept      = in_valid && in_ready && !clr;
    idleExpired = IDLE_EN && (idleCnt_q == IDLE_MAX);
    pushIdle    = !accept && holdValid_q && oFree && (holdLast_q || idleExpired);
    loadO       = (accept && holdValid_q && !merge) || pushIdle;
  end

  // Next state of the hold register.
  // A merging pixel can still close the run through in_last.
  always_comb begin
    holdValid_d = holdValid_q;
    holdBin_d   = holdBin_q;
    holdCnt_d   = holdCnt_q;
    holdLast_d  = holdLast_q;
    if (clr) begin
      holdValid_d = 1'b0;
    end else if (accept) begin
      if (merge) begin
        holdCnt_d  = holdCnt_q + CNT_W'(1);
        holdLast_d = in_last;
      end else begin
        holdValid_d = 1'b1;
        holdBin_d   = in_bin;
        holdCnt_d   = CNT_W'(1);
        holdLast_d  = in_last;
      end
    end else if (pushIdle) begin
      holdValid_d = 1'b0;
    end
  end

  // Idle counter. It saturates at IDLE_MAX, and the held run is flushed
  // once O can take it. With IDLE_CYC=0 it stays at zero and never expires.
  always_comb begin
    idleCnt_d = idleCnt_q;
    if (clr || accept || loadO) begin
      idleCnt_d = '0;
    end else if (holdValid_q && (idleCnt_q != IDLE_MAX)) begin
      idleCnt_d = idleCnt_q + IDLE_W'(1);
    end
  end

  // Next state of the output register.
  // The one-hot is cleared whenever the entry goes invalid, so downstream can
  // OR it straight into a bank select without also gating on out_valid.
  always_comb begin
    outValid_d  = outValid_q;
    outBin_d    = outBin_q;
    outCnt_d    = outCnt_q;
    outLast_d   = outLast_q;
    outOnehot_d = outOnehot_q;
    if (clr) begin
      outValid_d  = 1'b0;
      outOnehot_d = '0;
    end else if (loadO) begin
      outValid_d  = 1'b1;
      outBin_d    = holdBin_q;
      outCnt_d    = holdCnt_q;
      outLast_d   = holdLast_q;
      outOnehot_d = holdOnehot;
    end else if (out_ready) begin
      outValid_d  = 1'b0;
      outOnehot_d = '0;
    end
  end

  // State registers. On reset, any held run and any output run are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holdValid_q <= 1'b0;
      holdBin_q   <= '0;
      holdCnt_q   <= '0;
      holdLast_q  <= 1'b0;
      outValid_q  <= 1'b0;
      outBin_q    <= '0;
      outCnt_q    <= '0;
      outLast_q   <= 1'b0;
      outOnehot_q <= '0;
      idleCnt_q   <= '0;
    end else begin
      holdValid_q <= holdValid_d;
      holdBin_q   <= holdBin_d;
      holdCnt_q   <= holdCnt_d;
      holdLast_q  <= holdLast_d;
      outValid_q  <= outValid_d;
      outBin_q    <= outBin_d;
      outCnt_q    <= outCnt_d;
      outLast_q   <= outLast_d;
      outOnehot_q <= outOnehot_d;
      idleCnt_q   <= idleCnt_d;
    end
  end

  assign out_valid  = outValid_q;
  assign out_bin    = outBin_q;
  assign out_cnt    = outCnt_q;
  assign out_last   = outLast_q;
  assign out_onehot = outOnehot_q;

endmodule

// File: tb/tb_hist_bin_run_decoder.sv
// ---------------------------------------------------------------------------
// tb_hist_bin_run_decoder
// Self-checking bench for hist_bin_run_decoder with default parameters.
// Expected runs come from a run-length model of the pixel stream.
// ---------------------------------------------------------------------------
module tb_hist_bin_run_decoder;

  localparam int MAX_RUN = 255;

  typedef logic [45:0] ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_bin;
  logic        in_last;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_onehot;
  logic [4:0]  out_bin;
  logic [7:0]  out_cnt;
  logic        out_last;

  int   vectors = 0;
  int   errors  = 0;
  int   readyMode = 0;
  int   lowRun = 0;
  ent_t gotQ[$];
  ent_t expQ[$];
  bit   mOpen;
  int   mBin;
  int   mCnt;

  hist_bin_run_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bin     (in_bin),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .out_bin    (out_bin),
    .out_cnt    (out_cnt),
    .out_last   (out_last)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Downstream ready. Mode 0 holds it high and mode 1 holds it low. Mode 2
  // is random, but never low for more than 3 cycles in a row.
  always @(posedge clk) begin
    #2;
    case (readyMode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: begin
        if (lowRun >= 3 || $urandom_range(0, 3) != 0) begin
          out_ready = 1'b1;
          lowRun    = 0;
        end else begin
          out_ready = 1'b0;
          lowRun++;
        end
      end
    endcase
  end

  // Capture every output entry that downstream takes.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready)
      gotQ.push_back({out_onehot, out_bin, out_cnt, out_last});
  end

  function automatic ent_t mk(input int b, input int c, input bit l);
    ent_t e;
    e = {32'd1 << b, 5'(b), 8'(c), l};
    return e;
  endfunction

  // Run-length reference model. A run grows while the bin repeats, up to
  // MAX_RUN, and a last pixel always closes the run.
  task automatic modelPixel(input int b, input bit l);
    if (mOpen && b == mBin && mCnt < MAX_RUN) begin
      mCnt++;
    end else begin
      if (mOpen) expQ.push_back(mk(mBin, mCnt, 1'b0));
      mOpen = 1'b1;
      mBin  = b;
      mCnt  = 1;
    end
    if (l) begin
      expQ.push_back(mk(mBin, mCnt, 1'b1));
      mOpen = 1'b0;
    end
  endtask

  // Present one pixel and wait until it is accepted. Each call starts 1 time
  // unit after a rising edge and returns 1 time unit after one.
  task automatic applyStimulus(input int b, input bit l);
    bit acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_bin   = 5'(b);
    in_last  = l;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      vectors++;
      errors++;
      $display("[TB] FAIL accept_timeout: bin %0d in_ready stayed 0, expected 1", b);
    end
  endtask

  task automatic waitEntries(input int n, input int bound);
    for (int k = 0; k < bound && gotQ.size() < n; k++) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_bin = '0; in_last = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    vectors++;
    if (out_onehot !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_onehot: got %h expected 0", out_onehot);
    end
    vectors++;
    if ({out_bin, out_cnt, out_last} !== 14'h0) begin
      errors++; $display("[TB] FAIL reset_fields: got %h expected 0", {out_bin, out_cnt, out_last});
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL release_in_ready: got %b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_runs();
    ent_t exp[2];
    ent_t g;
    readyMode = 0;
    gotQ.delete();
    exp[0] = mk(3, 3, 1'b0);
    exp[1] = mk(7, 1, 1'b1);
    applyStimulus(3, 0); applyStimulus(3, 0); applyStimulus(3, 0); applyStimulus(7, 1);
    waitEntries(2, 50);
    vectors++;
    if (gotQ.size() != 2) begin
      errors++; $display("[TB] FAIL basic_count: got %0d expected 2", gotQ.size());
    end
    for (int i = 0; i < 2; i++) begin
      g = (i < gotQ.size()) ? gotQ[i] : '0;
      vectors++;
      if (g !== exp[i]) begin
        errors++; $display("[TB] FAIL basic_run%0d: got %h expected %h", i, g, exp[i]);
      end
    end
  endtask

  task automatic test_saturation();
    ent_t exp[2];
    ent_t g;
    readyMode = 0;
    gotQ.delete();
    exp[0] = mk(31, 255, 1'b0);
    exp[1] = mk(31, 45, 1'b1);
    for (int i = 0; i < 300; i++) applyStimulus(31, i == 299);
    waitEntries(2, 50);
    vectors++;
    if (gotQ.size() != 2) begin
      errors++; $display("[TB] FAIL sat_count: got %0d expected 2", gotQ.size());
    end
    for (int i = 0; i < 2; i++) begin
      g = (i < gotQ.size()) ? gotQ[i] : '0;
      vectors++;
      if (g !== exp[i]) begin
        errors++; $display("[TB] FAIL sat_run%0d: got %h expected %h", i, g, exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    ent_t exp[3];
    ent_t g;
    readyMode = 1;
    gotQ.delete();
    exp[0] = mk(1, 1, 1'b0);
    exp[1] = mk(2, 1, 1'b0);
    exp[2] = mk(3, 1, 1'b1);
    applyStimulus(1, 0);
    applyStimulus(2, 0);
    in_valid = 1'b1; in_bin = 5'd3; in_last = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || {out_onehot, out_bin, out_cnt, out_last} !== exp[0]) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d: got v=%b %h expected v=1 %h", k, out_valid,
                 {out_onehot, out_bin, out_cnt, out_last}, exp[0]);
      end
      vectors++;
      if (in_ready !== 1'b0) begin
        errors++; $display("[TB] FAIL stall_in_ready%0d: got %b expected 0", k, in_ready);
      end
    end
    @(posedge clk);
    #1;
    readyMode = 0;
    applyStimulus(3, 1);
    waitEntries(3, 50);
    vectors++;
    if (gotQ.size() != 3) begin
      errors++; $display("[TB] FAIL stall_count: got %0d expected 3", gotQ.size());
    end
    for (int i = 0; i < 3; i++) begin
      g = (i < gotQ.size()) ? gotQ[i] : '0;
      vectors++;
      if (g !== exp[i]) begin
        errors++; $display("[TB] FAIL stall_run%0d: got %h expected %h", i, g, exp[i]);
      end
    end
  endtask

  task automatic test_idle_flush();
    int   k;
    ent_t g;
    readyMode = 0;
    gotQ.delete();
    applyStimulus(5, 0);
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    // k counts edges after the accept edge; the pixel was presented one cycle earlier
    vectors++;
    if (k + 1 != 18) begin
      errors++; $display("[TB] FAIL idle_latency: got %0d cycles expected 18", k + 1);
    end
    waitEntries(1, 10);
    g = (gotQ.size() > 0) ? gotQ[0] : '0;
    vectors++;
    if (gotQ.size() != 1 || g !== mk(5, 1, 1'b0)) begin
      errors++; $display("[TB] FAIL idle_run: got %0d entries %h expected 1 entry %h",
                         gotQ.size(), g, mk(5, 1, 1'b0));
    end
  endtask

  task automatic test_clear();
    ent_t g;
    readyMode = 1;
    gotQ.delete();
    applyStimulus(4, 0);
    applyStimulus(6, 0);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL clr_pre_valid: got %b expected 1", out_valid);
    end
    @(posedge clk);
    #1;
    clr = 1'b1; in_valid = 1'b1; in_bin = 5'd6; in_last = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL clr_merge_ready: got %b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    clr = 1'b0; in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || out_onehot !== 32'h0) begin
      errors++; $display("[TB] FAIL clr_out: got v=%b oh=%h expected v=0 oh=0", out_valid, out_onehot);
    end
    readyMode = 0;
    repeat (30) @(posedge clk);
    #1;
    vectors++;
    if (gotQ.size() != 0) begin
      errors++; $display("[TB] FAIL clr_stale: got %0d entries expected 0", gotQ.size());
    end
    applyStimulus(10, 1);
    waitEntries(1, 20);
    g = (gotQ.size() > 0) ? gotQ[0] : '0;
    vectors++;
    if (gotQ.size() != 1 || g !== mk(10, 1, 1'b1)) begin
      errors++; $display("[TB] FAIL clr_after: got %0d entries %h expected 1 entry %h",
                         gotQ.size(), g, mk(10, 1, 1'b1));
    end
  endtask

  task automatic test_reset_mid_run();
    ent_t g;
    readyMode = 1;
    gotQ.delete();
    applyStimulus(2, 0);
    applyStimulus(9, 0);
    applyStimulus(9, 0);
    rst = 1'b1;
    #1;
    vectors++;
    if ({out_valid, out_onehot, out_bin, out_cnt, out_last, in_ready} !== 48'h0) begin
      errors++;
      $display("[TB] FAIL rst_mid_outputs: got %h expected 0",
               {out_valid, out_onehot, out_bin, out_cnt, out_last, in_ready});
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    readyMode = 0;
    applyStimulus(9, 1);
    waitEntries(1, 20);
    g = (gotQ.size() > 0) ? gotQ[0] : '0;
    vectors++;
    if (gotQ.size() != 1 || g !== mk(9, 1, 1'b1)) begin
      errors++; $display("[TB] FAIL rst_mid_first: got %0d entries %h expected 1 entry %h",
                         gotQ.size(), g, mk(9, 1, 1'b1));
    end
  endtask

  task automatic test_random();
    int   b;
    int   prev;
    bit   l;
    ent_t g;
    readyMode = 2;
    gotQ.delete();
    expQ.delete();
    mOpen = 1'b0;
    prev  = 0;
    for (int i = 0; i < 400; i++) begin
      if (i == 150) begin
        for (int j = 0; j < 270; j++) begin
          modelPixel(12, 1'b0);
          applyStimulus(12, 1'b0);
        end
      end
      if ($urandom_range(0, 1) == 0) b = prev;
      else if ($urandom_range(0, 7) == 0) b = $urandom_range(0, 31);
      else b = $urandom_range(0, 3);
      prev = b;
      l = (i == 399) || ($urandom_range(0, 39) == 0);
      modelPixel(b, l);
      applyStimulus(b, l);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    readyMode = 0;
    waitEntries(expQ.size(), 2000);
    vectors++;
    if (gotQ.size() != expQ.size()) begin
      errors++; $display("[TB] FAIL rand_count: got %0d expected %0d", gotQ.size(), expQ.size());
    end
    for (int i = 0; i < expQ.size(); i++) begin
      g = (i < gotQ.size()) ? gotQ[i] : '0;
      vectors++;
      if (g !== expQ[i]) begin
        errors++; $display("[TB] FAIL rand_run%0d: got %h expected %h", i, g, expQ[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_runs();
    test_saturation();
    test_backpressure();
    test_idle_flush();
    test_clear();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
